// File: rtl/delay_scan_seq_pkg.sv
// Shared pulse-generator definitions: delay-scan FSM encodings and default widths.
package delay_scan_seq_pkg;
  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_UPDATE = 3'd3,
    S_FIN    = 3'd4
  } scan_state_t;
endpackage

// File: rtl/delay_scan_seq_sync_edge.sv
// sync_on rising-edge detector: rise is combinational against a registered copy.
// Zero-cycle latency from input to rise; no backpressure.
module sync_edge (
  input  logic clk_pll,
  input  logic resetn,
  input  logic in,
  output logic rise
);
  logic in_q;

  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) in_q <= 1'b0;
    else         in_q <= in;
  end

  assign rise = in & ~in_q;
endmodule

// File: rtl/delay_scan_seq.sv
// Delay scan sequencer: steps delay_out through cfg_points values, cfg_avg shots each.
// New delay valid 2 cycles after the completing sync edge; start ignored while busy, abort wins.
module delay_scan_seq
  import delay_scan_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk_pll,
  input  logic          resetn,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] cfg_start,
  input  logic [DW-1:0] cfg_step,
  input  logic [CW-1:0] cfg_points,
  input  logic [CW-1:0] cfg_avg,
  input  logic          sync_on,
  output logic [DW-1:0] delay_out,
  output logic          block_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] point_idx,
  output logic [CW-1:0] shot_idx,
  output logic          ovf
);
  scan_state_t   state_q, state_d;
  logic [DW-1:0] step_q;
  logic [CW-1:0] points_q, avg_q;
  logic          pend_q;
  logic          rise, shot, shot_last, last_point, cfg_empty;
  logic [CW-1:0] shot_inc;
  logic [DW:0]   delay_sum;

  sync_edge u_sync_edge (
    .clk_pll (clk_pll),
    .resetn  (resetn),
    .in      (sync_on),
    .rise    (rise)
  );

  // A shot seen during UPDATE is parked in pend_q and counted on the first RUN cycle.
  assign shot       = rise | pend_q;
  assign shot_inc   = shot_idx + CW'(1);
  assign shot_last  = shot && (shot_inc == avg_q);
  assign last_point = (point_idx == points_q - CW'(1));
  assign cfg_empty  = (cfg_points == '0) || (cfg_avg == '0);
  assign delay_sum  = {1'b0, delay_out} + {1'b0, step_q};

  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    block_out = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = cfg_empty ? S_FIN : S_ARM;
      S_ARM: begin
        busy      = 1'b1;
        block_out = 1'b1;
        if (rise) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (shot_last) state_d = last_point ? S_FIN : S_UPDATE;
      end
      S_UPDATE: begin
        busy      = 1'b1;
        block_out = 1'b1;
        state_d   = S_RUN;
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk_pll or negedge resetn) begin
    if (!resetn) begin
      delay_out <= '0;
      point_idx <= '0;
      shot_idx  <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      pend_q    <= 1'b0;
      step_q    <= '0;
      points_q  <= '0;
      avg_q     <= '0;
    end else begin
      done <= (state_q == S_FIN) && !abort;
      if (abort) begin
        pend_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            step_q    <= cfg_step;
            points_q  <= cfg_points;
            avg_q     <= cfg_avg;
            point_idx <= '0;
            shot_idx  <= '0;
            ovf       <= 1'b0;
            pend_q    <= 1'b0;
            if (!cfg_empty) delay_out <= cfg_start;
          end
          S_RUN: begin
            pend_q <= 1'b0;
            if (shot) shot_idx <= shot_inc;
          end
          S_UPDATE: begin
            pend_q    <= rise;
            point_idx <= point_idx + CW'(1);
            shot_idx  <= '0;
            if (delay_sum[DW]) begin
              delay_out <= '1;
              ovf       <= 1'b1;
            end else begin
              delay_out <= delay_sum[DW-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_delay_scan_seq.sv
// Scoreboard bench for delay_scan_seq: stimulus queues expected delay steps and done snapshots.
module tb_delay_scan_seq;
  logic        clk_pll = 1'b0;
  logic        resetn  = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [31:0] cfg_start = '0;
  logic [31:0] cfg_step  = '0;
  logic [15:0] cfg_points = '0;
  logic [15:0] cfg_avg    = '0;
  logic        sync_on = 1'b0;
  logic [31:0] delay_out;
  logic        block_out, busy, done, ovf;
  logic [15:0] point_idx, shot_idx;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] p;
    logic [15:0] s;
    logic        o;
  } done_t;

  logic [31:0] exp_delay_q[$];
  done_t       exp_done_q[$];
  logic [31:0] prev_delay = '0;
  int          checks = 0;
  int          errors = 0;

  delay_scan_seq #(.DW(32), .CW(16)) dut (
    .clk_pll    (clk_pll),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .cfg_start  (cfg_start),
    .cfg_step   (cfg_step),
    .cfg_points (cfg_points),
    .cfg_avg    (cfg_avg),
    .sync_on    (sync_on),
    .delay_out  (delay_out),
    .block_out  (block_out),
    .busy       (busy),
    .done       (done),
    .point_idx  (point_idx),
    .shot_idx   (shot_idx),
    .ovf        (ovf)
  );

  always #5 clk_pll = ~clk_pll;

  // Monitor: every delay_out change and every done pulse must match the head of its queue.
  always @(negedge clk_pll) begin
    if (!resetn) begin
      prev_delay = delay_out;
    end else begin
      if (delay_out !== prev_delay) begin
        checks++;
        if (exp_delay_q.size() == 0) begin
          errors++;
          $display("FAIL delay_step: got %h, none expected", delay_out);
        end else begin
          logic [31:0] e;
          e = exp_delay_q.pop_front();
          if (delay_out !== e) begin
            errors++;
            $display("FAIL delay_step: got %h expected %h", delay_out, e);
          end
        end
        prev_delay = delay_out;
      end
      if (done) begin
        done_t got;
        got = '{d: delay_out, p: point_idx, s: shot_idx, o: ovf};
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_pulse: unexpected done, delay %h point %0d", delay_out, point_idx);
        end else begin
          done_t e;
          e = exp_done_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL done_snapshot: got d=%h p=%0d s=%0d o=%b expected d=%h p=%0d s=%0d o=%b",
                     got.d, got.p, got.s, got.o, e.d, e.p, e.s, e.o);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pll);
    #1;
  endtask

  task automatic pulse(input int gap);
    sync_on = 1'b1;
    tick(1);
    sync_on = 1'b0;
    tick(gap);
  endtask

  // Config is scrambled right after start to confirm the captured copy is used.
  task automatic do_start(input logic [31:0] s, input logic [31:0] st,
                          input logic [15:0] p, input logic [15:0] a);
    cfg_start = s; cfg_step = st; cfg_points = p; cfg_avg = a;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cfg_start = 32'h0BAD_0000; cfg_step = 32'h0000_0777; cfg_points = 16'd9; cfg_avg = 16'd5;
  endtask

  initial begin
    tick(2);
    chk("reset_outputs", {delay_out, point_idx, shot_idx, ovf, busy, done, block_out},
        64'h0);
    resetn = 1'b1;
    tick(2);

    // Basic scan: 100/120/140, two shots each.
    exp_delay_q.push_back(32'd100);
    exp_delay_q.push_back(32'd120);
    exp_delay_q.push_back(32'd140);
    exp_done_q.push_back('{d: 32'd140, p: 16'd2, s: 16'd2, o: 1'b0});
    do_start(32'd100, 32'd20, 16'd3, 16'd2);
    chk("arm_busy_block", {busy, block_out}, 64'h3);
    pulse(3);
    chk("run_block_low", block_out, 64'h0);
    pulse(3);
    chk("first_counted", shot_idx, 64'd1);
    sync_on = 1'b1;
    tick(1);
    chk("update_block", {block_out, busy}, 64'h3);
    chk("update_delay_old", delay_out, 64'd100);
    sync_on = 1'b0;
    tick(1);
    chk("delay_after_2cyc", delay_out, 64'd120);
    chk("point_after_upd", {point_idx, shot_idx}, {32'h0, 16'd1, 16'd0});
    tick(2);
    repeat (5) pulse(3);
    chk("basic_end", {busy, delay_out}, {31'h0, 1'b0, 32'd140});

    // Empty configuration: straight to FIN, delay untouched.
    exp_done_q.push_back('{d: 32'd140, p: 16'd0, s: 16'd0, o: 1'b0});
    do_start(32'd555, 32'd1, 16'd0, 16'd2);
    chk("empty_cyc1", {done, busy}, 64'h0);
    tick(1);
    chk("empty_done_cyc2", {done, busy}, 64'h2);
    chk("empty_delay", delay_out, 64'd140);
    tick(1);
    chk("empty_done_single", done, 64'h0);
    tick(2);

    // Saturation on the second point.
    exp_delay_q.push_back(32'hFFFF_FFF0);
    exp_delay_q.push_back(32'hFFFF_FFFF);
    exp_done_q.push_back('{d: 32'hFFFF_FFFF, p: 16'd1, s: 16'd1, o: 1'b1});
    do_start(32'hFFFF_FFF0, 32'h20, 16'd2, 16'd1);
    repeat (3) pulse(3);
    tick(3);
    chk("ovf_sticky", {ovf, busy}, 64'h2);

    // Abort in RUN at point 1, with a simultaneous start.
    exp_delay_q.push_back(32'd100);
    exp_delay_q.push_back(32'd120);
    do_start(32'd100, 32'd20, 16'd3, 16'd2);
    chk("start_clears_ovf", ovf, 64'h0);
    repeat (4) pulse(3);
    chk("pre_abort", {point_idx, shot_idx}, {32'h0, 16'd1, 16'd1});
    abort = 1'b1; start = 1'b1; cfg_start = 32'd500; cfg_points = 16'd3; cfg_avg = 16'd2;
    tick(1);
    abort = 1'b0; start = 1'b0;
    chk("abort_idle", {busy, block_out}, 64'h0);
    chk("abort_hold", {delay_out, point_idx}, {16'h0, 32'd120, 16'd1});
    pulse(3);
    chk("abort_start_ignored", {busy, delay_out}, {31'h0, 1'b0, 32'd120});

    // Back-to-back sync edges across an UPDATE cycle.
    exp_delay_q.push_back(32'd100);
    exp_delay_q.push_back(32'd120);
    exp_done_q.push_back('{d: 32'd120, p: 16'd1, s: 16'd1, o: 1'b0});
    do_start(32'd100, 32'd20, 16'd2, 16'd1);
    pulse(3);
    sync_on = 1'b1;
    tick(1);
    chk("fast_update", block_out, 64'h1);
    sync_on = 1'b0;
    tick(1);
    sync_on = 1'b1;
    tick(1);
    chk("fast_shot_counted", {point_idx, shot_idx}, {32'h0, 16'd1, 16'd1});
    sync_on = 1'b0;
    tick(3);

    // Asynchronous reset mid-RUN, then a full rerun.
    exp_delay_q.push_back(32'd100);
    exp_delay_q.push_back(32'd120);
    do_start(32'd100, 32'd20, 16'd3, 16'd2);
    repeat (4) pulse(3);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset", {delay_out, point_idx, shot_idx, ovf, busy, done, block_out}, 64'h0);
    tick(2);
    resetn = 1'b1;
    pulse(3);
    chk("post_reset_idle", {busy, delay_out}, 64'h0);
    exp_delay_q.push_back(32'd100);
    exp_delay_q.push_back(32'd120);
    exp_delay_q.push_back(32'd140);
    exp_done_q.push_back('{d: 32'd140, p: 16'd2, s: 16'd2, o: 1'b0});
    do_start(32'd100, 32'd20, 16'd3, 16'd2);
    repeat (7) pulse(3);
    tick(3);

    chk("delay_queue_drained", exp_delay_q.size(), 64'd0);
    chk("done_queue_drained", exp_done_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
